// File: rtl/ai_mc_pkg.sv
// Shared types and limits for the memory-controller read scheduler.
package ai_mc_pkg;

  localparam int MC_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } mc_sched_state_e;

endpackage

// File: rtl/ai_mc_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module ai_mc_rr_pick
  import ai_mc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(MC_MAX_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  int unsigned        idx;
  logic [NUM_REQ-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = req >> idx;
      if (!any && sel[0]) begin
        any       = 1'b1;
        grant     = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
        grant_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ai_mc_rd_sched.sv
// Round-robin scheduler sharing one memory-controller read channel among
// NUM_REQ burst requesters; the grant is held until the last beat is delivered.
module ai_mc_rd_sched
  import ai_mc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic                      mc_cmd_valid,
  input  logic                      mc_cmd_ready,
  output logic [ADDR_W-1:0]         mc_cmd_addr,
  output logic [LEN_W-1:0]          mc_cmd_len,
  input  logic                      mc_rd_valid,
  output logic                      mc_rd_ready,
  input  logic [DATA_W-1:0]         mc_rd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  input  logic [NUM_REQ-1:0]        rd_ready,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_last,
  output logic                      busy,
  output logic                      len_err
);

  localparam int IDX_W = $clog2(MC_MAX_REQ);

  mc_sched_state_e    state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, grant_q, pick_idx;
  logic [NUM_REQ-1:0] grant_oh_q, pick_grant;
  logic               pick_any;
  logic [ADDR_W-1:0]  addr_q, sel_addr;
  logic [LEN_W-1:0]   len_q, cnt_q, sel_len;
  logic               accept, cmd_fire, beat_fire, last_fire, sel_ready;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) + 1 >= NUM_REQ) ? '0 : i + IDX_W'(1);
  endfunction

  ai_mc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign sel_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign sel_len   = req_len[int'(pick_idx)*LEN_W +: LEN_W];
  assign sel_ready = |(rd_ready & grant_oh_q);

  // Gating with rst keeps req_ready low while reset is held even though IDLE.
  assign accept    = (state_q == IDLE) && pick_any && !rst;
  assign cmd_fire  = (state_q == CMD) && mc_cmd_ready;
  assign beat_fire = (state_q == DATA) && mc_rd_valid && sel_ready;
  assign last_fire = beat_fire && (cnt_q == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && sel_len != '0) state_d = CMD;
      CMD:     if (cmd_fire) state_d = DATA;
      DATA:    if (last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = accept ? pick_grant : '0;
    mc_cmd_valid = (state_q == CMD);
    mc_rd_ready  = (state_q == DATA) && sel_ready;
    rd_valid     = (state_q == DATA) ? (grant_oh_q & {NUM_REQ{mc_rd_valid}}) : '0;
    rd_data      = (state_q == DATA) ? mc_rd_data : '0;
    rd_last      = (state_q == DATA) && mc_rd_valid && (cnt_q == LEN_W'(1));
    busy         = (state_q != IDLE);
  end

  assign mc_cmd_addr = addr_q;
  assign mc_cmd_len  = len_q;

  // A zero-length request is consumed in IDLE: flag it and move the pointer on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      len_err    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= sel_addr;
        len_q      <= sel_len;
        grant_q    <= pick_idx;
        grant_oh_q <= pick_grant;
        if (sel_len == '0) begin
          len_err <= 1'b1;
          ptr_q   <= wrap_inc(pick_idx);
        end
      end
      if (cmd_fire)  cnt_q <= len_q;
      if (beat_fire) cnt_q <= cnt_q - LEN_W'(1);
      if (last_fire) ptr_q <= wrap_inc(grant_q);
    end
  end

endmodule

// File: tb/tb_ai_mc_rd_sched.sv
// Directed bench for ai_mc_rd_sched: a burst table plus hand sequences for
// zero-length, mid-burst reset and a narrow-counter maximum-length burst.
module tb_ai_mc_rd_sched;

  logic        clk = 1'b0;
  logic        rst;

  logic [2:0]  req_valid, req_ready, rd_valid, rd_ready;
  logic [95:0] req_addr;
  logic [47:0] req_len;
  logic        mc_cmd_valid, mc_cmd_ready, mc_rd_valid, mc_rd_ready;
  logic [31:0] mc_cmd_addr, mc_rd_data, rd_data;
  logic [15:0] mc_cmd_len;
  logic        rd_last, busy, len_err;

  logic [1:0]  req_valid_b, req_ready_b, rd_valid_b, rd_ready_b;
  logic [31:0] req_addr_b;
  logic [7:0]  req_len_b;
  logic        mc_cmd_valid_b, mc_cmd_ready_b, mc_rd_valid_b, mc_rd_ready_b;
  logic [15:0] mc_cmd_addr_b;
  logic [3:0]  mc_cmd_len_b;
  logic [7:0]  mc_rd_data_b, rd_data_b;
  logic        rd_last_b, busy_b, len_err_b;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0]  valid;
    logic [31:0] base;
    logic [15:0] len;
    int          g;
    logic [31:0] ea;
    int          cmd_delay;
    int          stall_at;
    int          stall_cycles;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  ai_mc_rd_sched #(.NUM_REQ(3), .ADDR_W(32), .LEN_W(16), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .mc_cmd_valid(mc_cmd_valid), .mc_cmd_ready(mc_cmd_ready),
    .mc_cmd_addr(mc_cmd_addr), .mc_cmd_len(mc_cmd_len),
    .mc_rd_valid(mc_rd_valid), .mc_rd_ready(mc_rd_ready), .mc_rd_data(mc_rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .len_err(len_err)
  );

  ai_mc_rd_sched #(.NUM_REQ(2), .ADDR_W(16), .LEN_W(4), .DATA_W(8)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b), .req_len(req_len_b),
    .mc_cmd_valid(mc_cmd_valid_b), .mc_cmd_ready(mc_cmd_ready_b),
    .mc_cmd_addr(mc_cmd_addr_b), .mc_cmd_len(mc_cmd_len_b),
    .mc_rd_valid(mc_rd_valid_b), .mc_rd_ready(mc_rd_ready_b), .mc_rd_data(mc_rd_data_b),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_data(rd_data_b), .rd_last(rd_last_b),
    .busy(busy_b), .len_err(len_err_b)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply_stimulus(input vec_t v);
    req_valid = v.valid;
    req_addr  = {v.base + 32'h20, v.base + 32'h10, v.base};
    req_len   = {v.len, v.len, v.len};
  endtask

  // Starts just after a rising edge in IDLE with requests already driven.
  task automatic run_burst(input int g, input logic [31:0] ea, input logic [15:0] el,
                           input int cmd_delay, input int stall_at, input int stall_cycles);
    int   beat;
    int   stalled;
    logic g_ready;
    @(negedge clk);
    check_output("accept_ready", req_ready, 3'b001 << g);
    check_output("idle_busy", busy, 0);
    @(posedge clk); #1;
    for (int c = 0; c <= cmd_delay; c++) begin
      mc_cmd_ready = (c == cmd_delay);
      mc_rd_valid  = 1'b1;
      rd_ready     = 3'b111;
      @(negedge clk);
      check_output("cmd_valid", mc_cmd_valid, 1);
      check_output("cmd_addr", mc_cmd_addr, ea);
      check_output("cmd_len", mc_cmd_len, el);
      check_output("cmd_no_stray_beat", {rd_valid, mc_rd_ready}, 0);
      check_output("cmd_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    mc_cmd_ready = 1'b0;
    beat    = 0;
    stalled = 0;
    for (int c = 0; c < int'(el) + stall_cycles + 4 && beat < int'(el); c++) begin
      mc_rd_valid = 1'b1;
      mc_rd_data  = {8'(g), 8'hA5, 16'(beat)};
      rd_ready    = 3'b111;
      g_ready     = 1'b1;
      if (beat == stall_at && stalled < stall_cycles) begin
        rd_ready = ~(3'b001 << g);
        g_ready  = 1'b0;
        stalled++;
      end
      @(negedge clk);
      check_output("beat_valid", rd_valid, 3'b001 << g);
      check_output("beat_data", rd_data, {8'(g), 8'hA5, 16'(beat)});
      check_output("beat_mc_ready", mc_rd_ready, g_ready);
      check_output("beat_last", rd_last, (beat == int'(el) - 1));
      if (g_ready) beat++;
      @(posedge clk); #1;
    end
    check_output("beat_count", beat, el);
    mc_rd_valid = 1'b0;
    rd_ready    = 3'b000;
    #1;
    check_output("done_idle", busy, 0);
    check_output("done_no_valid", {rd_valid, mc_rd_ready}, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beat;
    vecs[0] = '{3'b111, 32'h2000, 16'd2, 0, 32'h2000, 0, -1, 0};
    vecs[1] = '{3'b111, 32'h2000, 16'd2, 1, 32'h2010, 0, -1, 0};
    vecs[2] = '{3'b111, 32'h2000, 16'd2, 2, 32'h2020, 0, -1, 0};
    vecs[3] = '{3'b111, 32'h2000, 16'd2, 0, 32'h2000, 0, -1, 0};
    vecs[4] = '{3'b111, 32'h2000, 16'd2, 1, 32'h2010, 0, -1, 0};
    vecs[5] = '{3'b111, 32'h2000, 16'd2, 2, 32'h2020, 0, -1, 0};
    vecs[6] = '{3'b010, 32'h00F0, 16'd4, 1, 32'h0100, 0, -1, 0};
    vecs[7] = '{3'b001, 32'h0300, 16'd3, 0, 32'h0300, 0,  1, 5};
    vecs[8] = '{3'b101, 32'h0400, 16'd1, 2, 32'h0420, 0, -1, 0};
    vecs[9] = '{3'b110, 32'h0500, 16'd2, 1, 32'h0510, 2, -1, 0};

    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_len = '0;
    mc_cmd_ready = 1'b0; mc_rd_valid = 1'b0; mc_rd_data = '0; rd_ready = '0;
    req_valid_b = '0; req_addr_b = '0; req_len_b = '0;
    mc_cmd_ready_b = 1'b0; mc_rd_valid_b = 1'b0; mc_rd_data_b = '0; rd_ready_b = '0;
    #1;
    check_output("rst_busy", busy, 0);
    check_output("rst_req_ready", req_ready, 0);
    check_output("rst_cmd_valid", mc_cmd_valid, 0);
    check_output("rst_len_err", len_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i]);
      run_burst(vecs[i].g, vecs[i].ea, vecs[i].len,
                vecs[i].cmd_delay, vecs[i].stall_at, vecs[i].stall_cycles);
    end

    // Zero-length request from requester 2 (pointer is at 2 here).
    req_valid = 3'b100;
    req_len   = {16'd0, 16'd5, 16'd5};
    @(negedge clk);
    check_output("zl_ready", req_ready, 3'b100);
    check_output("zl_no_cmd", mc_cmd_valid, 0);
    @(posedge clk); #1;
    req_valid = 3'b000;
    #1;
    check_output("zl_err_set", len_err, 1);
    check_output("zl_idle", busy, 0);
    check_output("zl_no_cmd2", mc_cmd_valid, 0);
    req_valid = 3'b111;
    req_len   = {16'd1, 16'd1, 16'd1};
    req_addr  = {32'h620, 32'h610, 32'h600};
    run_burst(0, 32'h600, 16'd1, 0, -1, 0);
    check_output("zl_err_sticky", len_err, 1);

    // Reset during beat 2 of an 8-beat burst (pointer is at 1 here).
    req_valid = 3'b001;
    req_len   = {16'd8, 16'd8, 16'd8};
    req_addr  = {32'h720, 32'h710, 32'h700};
    @(negedge clk);
    check_output("rr_accept", req_ready, 3'b001);
    @(posedge clk); #1;
    mc_cmd_ready = 1'b1;
    @(posedge clk); #1;
    mc_cmd_ready = 1'b0;
    mc_rd_valid  = 1'b1;
    mc_rd_data   = 32'h1;
    rd_ready     = 3'b111;
    req_valid    = 3'b111;
    @(posedge clk); #1;
    mc_rd_data = 32'h2;
    @(negedge clk);
    check_output("rr_beat2_valid", rd_valid, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    check_output("rr_busy", busy, 0);
    check_output("rr_rd_valid", rd_valid, 0);
    check_output("rr_mc_rd_ready", mc_rd_ready, 0);
    check_output("rr_req_ready", req_ready, 0);
    check_output("rr_cmd_valid", mc_cmd_valid, 0);
    check_output("rr_rd_last_data", {rd_last, rd_data}, 0);
    check_output("rr_cmd_addr_len", {mc_cmd_addr, mc_cmd_len}, 0);
    check_output("rr_len_err", len_err, 0);
    req_valid = 3'b000; mc_rd_valid = 1'b0; rd_ready = 3'b000; mc_rd_data = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    req_valid = 3'b111;
    req_len   = {16'd2, 16'd2, 16'd2};
    req_addr  = {32'h820, 32'h810, 32'h800};
    run_burst(0, 32'h800, 16'd2, 0, -1, 0);
    req_valid = 3'b000;

    // Narrow counter: 15-beat burst on a 4-bit length, command ready late.
    req_valid_b = 2'b10;
    req_addr_b  = {16'hBEEF, 16'h1111};
    req_len_b   = {4'd15, 4'd3};
    @(negedge clk);
    check_output("b_accept", req_ready_b, 2'b10);
    @(posedge clk); #1;
    req_valid_b = 2'b00;
    for (int c = 0; c <= 3; c++) begin
      mc_cmd_ready_b = (c == 3);
      @(negedge clk);
      check_output("b_cmd_valid", mc_cmd_valid_b, 1);
      check_output("b_cmd_addr", mc_cmd_addr_b, 16'hBEEF);
      check_output("b_cmd_len", mc_cmd_len_b, 4'd15);
      @(posedge clk); #1;
    end
    mc_cmd_ready_b = 1'b0;
    beat = 0;
    for (int c = 0; c < 20 && beat < 15; c++) begin
      mc_rd_valid_b = 1'b1;
      mc_rd_data_b  = 8'(beat + 'h40);
      rd_ready_b    = 2'b11;
      @(negedge clk);
      check_output("b_beat_valid", rd_valid_b, 2'b10);
      check_output("b_beat_data", rd_data_b, 8'(beat + 'h40));
      check_output("b_beat_last", rd_last_b, (beat == 14));
      beat++;
      @(posedge clk); #1;
    end
    check_output("b_beat_count", beat, 15);
    #1;
    check_output("b_done_idle", busy_b, 0);
    check_output("b_stray_stalled", {rd_valid_b, mc_rd_ready_b}, 0);
    mc_rd_valid_b = 1'b0;
    req_valid_b   = 2'b11;
    #1;
    check_output("b_ptr_wrapped", req_ready_b, 2'b01);
    req_valid_b = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
